// File: rtl/mmu_load_ctrl.sv
// mmu_load_ctrl: loads a 2x2 weight and a 2x2 input matrix from a host byte stream,
// then sequences the feeder's compute phase (en, mmu_cycle) until feeder_done.
//
// Ports:
//   clk, rst (async, active-low)  | host_data, host_valid -> load_ready
//   weight0..3, input0..3 (row-major) | en, mmu_cycle, busy -> feeder | feeder_done <- feeder
// Build option: define MMU_LOAD_DOUBLE_BUFFER_EN to load the next matrix into a
// shadow bank while the active bank is being computed on.

module mmu_load_ctrl #(
    parameter int DATA_W     = 8,
    parameter int NUM_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_valid,
    output logic              load_ready,
    output logic [DATA_W-1:0] weight0,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] weight3,
    output logic [DATA_W-1:0] input0,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [DATA_W-1:0] input3,
    output logic              en,
    output logic [2:0]        mmu_cycle,
    input  logic              feeder_done,
    output logic              busy
);

    typedef enum logic {S_LOAD, S_RUN} state_e;

    localparam logic [2:0] CYC_MAX = 3'(NUM_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        cyc_q, cyc_d;
    logic [DATA_W-1:0] act_q [8];
    logic [DATA_W-1:0] act_d [8];
    logic              xfer;

    assign xfer = host_valid & load_ready;

`ifdef MMU_LOAD_DOUBLE_BUFFER_EN
    logic [DATA_W-1:0] sh_q [8];
    logic [DATA_W-1:0] sh_d [8];
    logic [2:0]        sh_cnt_q, sh_cnt_d;
    logic              full_q, full_d;
    logic              swap;

    assign swap = full_q & ((state_q == S_LOAD) | feeder_done);
    // Swapping frees the shadow bank, so a byte can land in slot 0 that same cycle.
    assign load_ready = ~full_q | swap;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        act_d    = act_q;
        sh_d     = sh_q;
        sh_cnt_d = sh_cnt_q;
        full_d   = full_q;
        if (swap) begin
            act_d   = sh_q;
            full_d  = 1'b0;
            state_d = S_RUN;
            cyc_d   = 3'd0;
        end else if (state_q == S_LOAD) begin
            cyc_d = 3'd0;
        end else if (feeder_done) begin
            state_d = S_LOAD;
            cyc_d   = 3'd0;
        end else begin
            cyc_d = (cyc_q == CYC_MAX) ? 3'd0 : cyc_q + 3'd1;
        end
        if (xfer) begin
            sh_d[sh_cnt_q] = host_data;
            sh_cnt_d       = sh_cnt_q + 3'd1;
            if (sh_cnt_q == 3'd7) full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_cnt_q <= 3'd0;
            full_q   <= 1'b0;
            for (int i = 0; i < 8; i++) sh_q[i] <= '0;
        end else begin
            sh_cnt_q <= sh_cnt_d;
            full_q   <= full_d;
            sh_q     <= sh_d;
        end
    end
`else
    logic [2:0] cnt_q, cnt_d;

    assign load_ready = (state_q == S_LOAD);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOAD: begin
                cyc_d = 3'd0;
                if (xfer) begin
                    act_d[cnt_q] = host_data;
                    cnt_d        = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (feeder_done) begin
                    state_d = S_LOAD;
                    cyc_d   = 3'd0;
                end else begin
                    cyc_d = (cyc_q == CYC_MAX) ? 3'd0 : cyc_q + 3'd1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 3'd0;
        else      cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            cyc_q   <= 3'd0;
            for (int i = 0; i < 8; i++) act_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            act_q   <= act_d;
        end
    end

    assign weight0   = act_q[0];
    assign weight1   = act_q[1];
    assign weight2   = act_q[2];
    assign weight3   = act_q[3];
    assign input0    = act_q[4];
    assign input1    = act_q[5];
    assign input2    = act_q[6];
    assign input3    = act_q[7];
    assign en        = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign mmu_cycle = cyc_q;

endmodule

// File: tb/tb_mmu_load_ctrl.sv
// tb_mmu_load_ctrl: directed table-driven bench for mmu_load_ctrl,
// plus hand-written reset, gapped-load and double-buffer sequences.

module tb_mmu_load_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] host_data;
    logic       host_valid;
    logic       load_ready;
    logic [7:0] weight0, weight1, weight2, weight3;
    logic [7:0] input0, input1, input2, input3;
    logic       en;
    logic [2:0] mmu_cycle;
    logic       feeder_done;
    logic       busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mmu_load_ctrl #(.DATA_W(8), .NUM_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_data  (host_data),
        .host_valid (host_valid),
        .load_ready (load_ready),
        .weight0    (weight0),
        .weight1    (weight1),
        .weight2    (weight2),
        .weight3    (weight3),
        .input0     (input0),
        .input1     (input1),
        .input2     (input2),
        .input3     (input3),
        .en         (en),
        .mmu_cycle  (mmu_cycle),
        .feeder_done(feeder_done),
        .busy       (busy)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       done;
        logic       pre_ready;
        logic       post_en;
        logic [2:0] post_cyc;
        logic       post_ready;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] rd(input int i);
        case (i)
            0: return weight0;
            1: return weight1;
            2: return weight2;
            3: return weight3;
            4: return input0;
            5: return input1;
            6: return input2;
            default: return input3;
        endcase
    endfunction

    task automatic chk_regs(input string nm, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] e;
        e = base;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s[%0d]", nm, i), 32'(rd(i)), 32'(e));
            e = e + step;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input bit gap);
        if (gap) begin
            host_valid = 1'b0;
            tick();
        end
        host_valid = 1'b1;
        host_data  = d;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic done,
                       input logic pr, input logic pe, input logic [2:0] pc,
                       input logic pq);
        vec_t t;
        t.v = v; t.d = d; t.done = done; t.pre_ready = pr;
        t.post_en = pe; t.post_cyc = pc; t.post_ready = pq;
        tbl.push_back(t);
    endtask

    initial begin
        rst         = 1'b0;
        host_valid  = 1'b0;
        host_data   = 8'h00;
        feeder_done = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Reset mid-stream: three bytes in, then async reset.
        for (int i = 0; i < 3; i++) load_byte(8'h99, 1'b0);
        chk("pre_rst_w0", 32'(weight0), 32'h99);
        #2 rst = 1'b0;
        #1 chk("async_rst_w0", 32'(weight0), 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk_regs("rst_regs", 8'h00, 8'h00);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cyc", 32'(mmu_cycle), 32'd0);

`ifndef MMU_LOAD_DOUBLE_BUFFER_EN
        // Done while loading is ignored.
        feeder_done = 1'b1;
        tick();
        feeder_done = 1'b0;
        chk("done_in_load_en", 32'(en), 32'd0);
        chk("done_in_load_ready", 32'(load_ready), 32'd1);

        // Load 1..8, run 9 cycles with 0xAA offered, then done.
        for (int i = 0; i < 8; i++)
            add(1'b1, 8'(i + 1), 1'b0, 1'b1, (i == 7), 3'd0, (i != 7));
        for (int k = 0; k < 9; k++)
            add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 3'((k + 1) % 8), 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);

        for (int n = 0; n < tbl.size(); n++) begin
            host_valid  = tbl[n].v;
            host_data   = tbl[n].d;
            feeder_done = tbl[n].done;
            #1 chk($sformatf("v%0d_pre_ready", n), 32'(load_ready), 32'(tbl[n].pre_ready));
            tick();
            chk($sformatf("v%0d_en", n), 32'(en), 32'(tbl[n].post_en));
            chk($sformatf("v%0d_busy", n), 32'(busy), 32'(tbl[n].post_en));
            chk($sformatf("v%0d_cyc", n), 32'(mmu_cycle), 32'(tbl[n].post_cyc));
            chk($sformatf("v%0d_ready", n), 32'(load_ready), 32'(tbl[n].post_ready));
        end
        host_valid  = 1'b0;
        feeder_done = 1'b0;
        chk_regs("loaded", 8'h01, 8'h01);

        // Count must still be 0: next byte lands in weight0 only.
        load_byte(8'h11, 1'b0);
        chk("cnt_kept_w0", 32'(weight0), 32'h11);
        chk("cnt_kept_w1", 32'(weight1), 32'h02);

        // Gapped partial load then reset discards everything.
        for (int i = 0; i < 5; i++) load_byte(8'h50 + 8'(i), 1'b1);
        chk("gap_w1", 32'(weight1), 32'h50);
        chk("gap_en", 32'(en), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_regs("gap_rst", 8'h00, 8'h00);

        // Fresh gapped load.
        for (int i = 0; i < 8; i++) load_byte(8'h21 + 8'(i), (i % 2) == 0);
        chk_regs("fresh", 8'h21, 8'h01);
        chk("fresh_en", 32'(en), 32'd1);
        chk("fresh_cyc", 32'(mmu_cycle), 32'd0);
        repeat (3) tick();
        chk("fresh_cyc3", 32'(mmu_cycle), 32'd3);

        // Reset mid-RUN aborts at once.
        rst = 1'b0;
        #1;
        chk("runrst_en", 32'(en), 32'd0);
        chk("runrst_busy", 32'(busy), 32'd0);
        chk("runrst_cyc", 32'(mmu_cycle), 32'd0);
        chk("runrst_w0", 32'(weight0), 32'd0);
        tick();
        rst = 1'b1;
        #1 chk("runrst_ready", 32'(load_ready), 32'd1);
`else
        // Matrix A into shadow; swap happens the cycle after it fills.
        for (int i = 0; i < 8; i++) load_byte(8'h01 + 8'(i), 1'b0);
        chk("dbA_en_fill", 32'(en), 32'd0);
        tick();
        chk("dbA_en", 32'(en), 32'd1);
        chk("dbA_cyc", 32'(mmu_cycle), 32'd0);
        chk_regs("dbA", 8'h01, 8'h01);

        // Matrix B loads during RUN.
        for (int i = 0; i < 8; i++) load_byte(8'h31 + 8'(i), 1'b0);
        chk("dbB_ready_full", 32'(load_ready), 32'd0);
        chk("dbB_en_run", 32'(en), 32'd1);
        chk_regs("dbB_hold_A", 8'h01, 8'h01);
        feeder_done = 1'b1;
        tick();
        feeder_done = 1'b0;
        chk("dbB_en", 32'(en), 32'd1);
        chk("dbB_cyc", 32'(mmu_cycle), 32'd0);
        chk_regs("dbB", 8'h31, 8'h01);

        // Done with only 3 shadow bytes -> LOAD until 5 more arrive.
        for (int i = 0; i < 3; i++) load_byte(8'h41 + 8'(i), 1'b0);
        feeder_done = 1'b1;
        tick();
        feeder_done = 1'b0;
        chk("dbC_en_load", 32'(en), 32'd0);
        chk("dbC_ready", 32'(load_ready), 32'd1);
        for (int i = 3; i < 8; i++) load_byte(8'h41 + 8'(i), 1'b0);
        chk("dbC_en_fill", 32'(en), 32'd0);
        tick();
        chk("dbC_en", 32'(en), 32'd1);
        chk("dbC_cyc", 32'(mmu_cycle), 32'd0);
        chk_regs("dbC", 8'h41, 8'h01);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
